// File: rtl/nibble_serial_sub.sv
// Digit-serial subtractor: y = a - b, one DIGIT_W-bit digit per clock, LSB digit first.
// Optional condition flags (zf/sf/of) are built only when SUB_FLAGS_EN is defined.
module nibble_serial_sub #(
    parameter int WIDTH   = 64,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             borrow_bit,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    localparam int NDIG  = WIDTH / DIGIT_W;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               borrow_q, borrow_d;
    logic [DIGIT_W:0]   digit_sum;
    logic               last_digit;

    logic [DIGIT_W-1:0] a_dig [NDIG];
    logic [DIGIT_W-1:0] b_dig [NDIG];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digits
        assign a_dig[gi] = a_q[gi*DIGIT_W +: DIGIT_W];
        assign b_dig[gi] = b_q[gi*DIGIT_W +: DIGIT_W];
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        y_d        = y_q;
        borrow_d   = borrow_q;
        // Subtraction as a + ~b + 1: the initial carry of 1 supplies the +1.
        digit_sum  = {1'b0, a_dig[idx_q]} + {1'b0, ~b_dig[idx_q]} + {{DIGIT_W{1'b0}}, carry_q};
        last_digit = (idx_q == IDX_W'(NDIG - 1));
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                y_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = digit_sum[DIGIT_W-1:0];
                carry_d = digit_sum[DIGIT_W];
                if (last_digit) begin
                    borrow_d = ~digit_sum[DIGIT_W];
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            borrow_q <= borrow_d;
        end
    end

`ifdef SUB_FLAGS_EN
    logic zf_q, sf_q, of_q;

    // Flags are captured from the completed y so they are valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (state_q == S_RUN && last_digit) begin
            zf_q <= (y_d == '0);
            sf_q <= y_d[WIDTH-1];
            of_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign zf = zf_q;
    assign sf = sf_q;
    assign of = of_q;
`else
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign of = 1'b0;
`endif

    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign y          = y_q;
    assign borrow_bit = borrow_q;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// Randomized and directed bench for nibble_serial_sub against a plain-arithmetic reference.
module tb_nibble_serial_sub;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] a, b;
    logic        busy, done;
    logic [63:0] y;
    logic        borrow_bit, zf, sf, of;

    int total = 0;
    int bad   = 0;

    nibble_serial_sub dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .borrow_bit(borrow_bit),
        .zf(zf), .sf(sf), .of(of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] ye, output logic be,
                                  output logic ze, output logic se, output logic oe);
        ye = av - bv;
        be = (av < bv);
`ifdef SUB_FLAGS_EN
        ze = (ye == 64'd0);
        se = ye[63];
        oe = (av[63] != bv[63]) && (ye[63] != av[63]);
`else
        ze = 1'b0;
        se = 1'b0;
        oe = 1'b0;
`endif
    endfunction

    // Called at the sample right after the accepting edge; returns at the done sample.
    // poke=1 drives ignored start pulses with junk operands at samples 3 and 10.
    task automatic wait_done(input bit poke, input bit hold, output int lat, output int busy_n);
        int n = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            if (poke) begin
                if (n == 3 || n == 10) begin
                    start = 1'b1;
                    a = {$urandom, $urandom};
                    b = {$urandom, $urandom};
                end else begin
                    start = hold;
                end
            end
            n++;
            @(negedge clk);
        end
        lat = n + 1;
    endtask

    task automatic check_result(input string tag, input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] ye;
        logic be, ze, se, oe;
        model(av, bv, ye, be, ze, se, oe);
        $display("txn %s a=%h b=%h y=%h borrow=%b zf=%b sf=%b of=%b", tag, av, bv, y, borrow_bit, zf, sf, of);
        chk({tag, ".done"},   64'(done), 64'(1'b1));
        chk({tag, ".y"},      y, ye);
        chk({tag, ".borrow"}, 64'(borrow_bit), 64'(be));
        chk({tag, ".zf"},     64'(zf), 64'(ze));
        chk({tag, ".sf"},     64'(sf), 64'(se));
        chk({tag, ".of"},     64'(of), 64'(oe));
    endtask

    // Full single operation from IDLE; also checks latency, busy length and the one-cycle pulse.
    task automatic do_op(input string tag, input logic [63:0] av, input logic [63:0] bv, input bit poke);
        int lat, busy_n;
        logic [63:0] y_hold;
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(poke, 1'b0, lat, busy_n);
        start = 1'b0;
        chk({tag, ".latency"}, 64'(lat), 64'd17);
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'd16);
        check_result(tag, av, bv);
        y_hold = y;
        @(negedge clk);
        chk({tag, ".done_pulse"}, 64'(done), 64'd0);
        chk({tag, ".y_hold"}, y, y_hold);
    endtask

    initial begin
        int lat, busy_n, dcnt;
        logic [63:0] ra, rb, r1;
        logic be, ze, se, oe;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.y", y, 64'd0);
        chk("reset.borrow", 64'(borrow_bit), 64'd0);
        chk("reset.flags", {61'd0, zf, sf, of}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("d5m3", 64'd5, 64'd3, 1'b0);
        do_op("d3m5", 64'd3, 64'd5, 1'b0);
        do_op("dmin1", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
        do_op("deq", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        do_op("dzero", 64'd0, 64'd0, 1'b0);
        do_op("dmax", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
        do_op("dneg", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

        // Starts pulsed while busy must be ignored.
        do_op("ignore", 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1);

        // Start held through done: second op accepted back to back.
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        a = ra; b = rb; start = 1'b1;
        @(negedge clk);
        wait_done(1'b0, 1'b1, lat, busy_n);
        chk("b2b.latency1", 64'(lat), 64'd17);
        check_result("b2b.op1", ra, rb);
        model(ra, rb, r1, be, ze, se, oe);
        a = rb; b = ra;
        @(negedge clk);
        start = 1'b0;
        chk("b2b.busy_again", 64'(busy), 64'd1);
        chk("b2b.y_held", y, r1);
        wait_done(1'b0, 1'b0, lat, busy_n);
        chk("b2b.latency2", 64'(lat), 64'd17);
        check_result("b2b.op2", rb, ra);
        @(negedge clk);

        // Reset in the middle of RUN aborts without a done pulse.
        a = 64'hDEAD_BEEF_0000_1111; b = 64'h0000_0000_0000_2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.y", y, 64'd0);
        chk("abort.borrow", 64'(borrow_bit), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1 || busy === 1'b1) dcnt++;
            @(negedge clk);
        end
        chk("abort.no_done", 64'(dcnt), 64'd0);
        $display("txn abort busy=%b done=%b y=%h", busy, done, y);

        // Random operations, biased toward equal operands and sign-boundary values.
        for (int i = 0; i < 30; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: begin ra[63] = 1'b1; rb[63] = 1'b0; end
                2: begin ra[63] = 1'b0; rb[63] = 1'b1; end
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
